// File: rtl/cpu_pkg.sv
// Shared CPU constants and types.
// Holds the constant-bank vector indices so this sequencer and the constant
// bank always agree on where the interrupt vectors live, plus the sequencer
// state and cause encodings.
package cpu_pkg;

   localparam int unsigned SEL_WIDTH = 4;
   localparam int unsigned HWINT_VEC = 1;
   localparam int unsigned SWINT_VEC = 2;

   typedef enum logic [1:0] {
      IDLE,
      SAVE,
      VECTOR
   } int_state_e;

   typedef enum logic {
      CAUSE_HW,
      CAUSE_SW
   } int_cause_e;

endpackage

// File: rtl/int_sequencer_if.sv
// Interrupt sequencer bundle between CPU decode/status, the sequencer and the
// constant bank A port.
//   master : CPU side, drives hwint/swint/iret/int_en/boundary, observes the rest
//   slave  : sequencer side, the mirror image
// Requests : hwint (level), swint/iret (1-cycle pulses), int_en, boundary
// Controls : stall, save_pc, const_oe_a, const_sel_a[SEL_WIDTH], pc_ld, in_isr, cause
interface int_sequencer_if
   import cpu_pkg::*;
#(
   parameter int unsigned SEL_WIDTH = cpu_pkg::SEL_WIDTH
);
   logic                 hwint;
   logic                 swint;
   logic                 iret;
   logic                 int_en;
   logic                 boundary;
   logic                 stall;
   logic                 save_pc;
   logic                 const_oe_a;
   logic [SEL_WIDTH-1:0] const_sel_a;
   logic                 pc_ld;
   logic                 in_isr;
   logic                 cause;

   modport master (
      output hwint, swint, iret, int_en, boundary,
      input  stall, save_pc, const_oe_a, const_sel_a, pc_ld, in_isr, cause
   );

   modport slave (
      input  hwint, swint, iret, int_en, boundary,
      output stall, save_pc, const_oe_a, const_sel_a, pc_ld, in_isr, cause
   );
endinterface

// File: rtl/int_req_latch.sv
// Pending-request storage for the interrupt sequencer.
// pend_sw remembers a swint pulse that arrived off an instruction boundary.
// With HWINT_EDGE_EN defined, hwint is rising-edge detected and the edge is
// held in pend_hw until the sequencer takes it.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   swint_i        : software interrupt pulse (sets pend_sw)
//   sw_clr_i       : sequencer took the software request
//   hwint_i        : hardware interrupt level (HWINT_EDGE_EN only)
//   hw_clr_i       : sequencer took the hardware request (HWINT_EDGE_EN only)
//   pend_sw_o, pend_hw_o : pending flags
module int_req_latch (
   input  logic clk,
   input  logic rst,
   input  logic swint_i,
   input  logic sw_clr_i,
`ifdef HWINT_EDGE_EN
   input  logic hwint_i,
   input  logic hw_clr_i,
   output logic pend_hw_o,
`endif
   output logic pend_sw_o
);

   logic pend_sw_q, pend_sw_d;

   // A take consumes the request, so clear wins over a simultaneous set.
   always_comb begin
      pend_sw_d = pend_sw_q | swint_i;
      if (sw_clr_i) pend_sw_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) pend_sw_q <= 1'b0;
      else     pend_sw_q <= pend_sw_d;
   end

   assign pend_sw_o = pend_sw_q;

`ifdef HWINT_EDGE_EN
   logic hwint_hist_q;
   logic pend_hw_q, pend_hw_d;
   logic hw_edge;

   assign hw_edge = hwint_i & ~hwint_hist_q;

   // A fresh edge is a new event and survives a same-cycle clear.
   always_comb begin
      pend_hw_d = pend_hw_q;
      if (hw_clr_i) pend_hw_d = 1'b0;
      if (hw_edge)  pend_hw_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hwint_hist_q <= 1'b0;
         pend_hw_q    <= 1'b0;
      end else begin
         hwint_hist_q <= hwint_i;
         pend_hw_q    <= pend_hw_d;
      end
   end

   assign pend_hw_o = pend_hw_q;
`endif

endmodule

// File: rtl/int_sequencer.sv
// Interrupt entry/exit sequencer, directly upstream of the constant bank.
// On a taken request: SAVE (stall, save_pc) then VECTOR (stall, drive the
// constant bank A port with the vector index, pc_ld), then back to IDLE with
// in_isr set. iret in IDLE clears in_isr. Software requests beat hardware.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : int_sequencer_if.slave (requests in, sequencing controls out)
// Optional: define HWINT_EDGE_EN for rising-edge hwint with a pend_hw latch;
// undefined gives level-sensitive hwint.
module int_sequencer
   import cpu_pkg::*;
#(
   parameter int unsigned SEL_WIDTH = cpu_pkg::SEL_WIDTH,
   parameter int unsigned HWINT_VEC = cpu_pkg::HWINT_VEC,
   parameter int unsigned SWINT_VEC = cpu_pkg::SWINT_VEC
) (
   input logic            clk,
   input logic            rst,
   int_sequencer_if.slave bus
);

   int_state_e state_q, state_d;
   int_cause_e cause_q, cause_d;
   logic       in_isr_q, in_isr_d;
   logic       pend_sw;
   logic       hw_src;
   logic       sw_req, hw_req, take;

`ifdef HWINT_EDGE_EN
   logic pend_hw;

   int_req_latch u_req_latch (
      .clk       (clk),
      .rst       (rst),
      .swint_i   (bus.swint),
      .sw_clr_i  (take & sw_req),
      .hwint_i   (bus.hwint),
      .hw_clr_i  (take & ~sw_req),
      .pend_hw_o (pend_hw),
      .pend_sw_o (pend_sw)
   );

   assign hw_src = pend_hw;
`else
   int_req_latch u_req_latch (
      .clk       (clk),
      .rst       (rst),
      .swint_i   (bus.swint),
      .sw_clr_i  (take & sw_req),
      .pend_sw_o (pend_sw)
   );

   assign hw_src = bus.hwint;
`endif

   assign sw_req = bus.swint | pend_sw;
   assign hw_req = hw_src & bus.int_en & ~in_isr_q;
   assign take   = (state_q == IDLE) & bus.boundary & (sw_req | hw_req);

   always_comb begin
      state_d  = state_q;
      cause_d  = cause_q;
      in_isr_d = in_isr_q;
      unique case (state_q)
         IDLE: begin
            if (bus.iret && in_isr_q) in_isr_d = 1'b0;
            if (take) begin
               state_d = SAVE;
               cause_d = sw_req ? CAUSE_SW : CAUSE_HW;
            end
         end
         SAVE:   state_d = VECTOR;
         VECTOR: begin
            state_d  = IDLE;
            in_isr_d = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cause_q  <= CAUSE_HW;
         in_isr_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cause_q  <= cause_d;
         in_isr_q <= in_isr_d;
      end
   end

   // Moore outputs; the bank A port is enabled only in VECTOR so it floats otherwise.
   always_comb begin
      bus.stall       = 1'b0;
      bus.save_pc     = 1'b0;
      bus.const_oe_a  = 1'b0;
      bus.const_sel_a = '0;
      bus.pc_ld       = 1'b0;
      unique case (state_q)
         SAVE: begin
            bus.stall   = 1'b1;
            bus.save_pc = 1'b1;
         end
         VECTOR: begin
            bus.stall       = 1'b1;
            bus.const_oe_a  = 1'b1;
            bus.const_sel_a = (cause_q == CAUSE_SW) ? SEL_WIDTH'(SWINT_VEC) : SEL_WIDTH'(HWINT_VEC);
            bus.pc_ld       = 1'b1;
         end
         default: ;
      endcase
   end

   assign bus.in_isr = in_isr_q;
   assign bus.cause  = cause_q;

endmodule
